// File: rtl/hls_deadlock_monitor_gen.sv
// Parametrised dataflow-region deadlock monitor with child gating, a debounce and stall capture.
// Optional feature: define HLS_DEADLOCK_MON_STICKY_EN to latch BLOCKED until clear/reset.
module hls_deadlock_monitor_gen #(
    parameter int unsigned         NUM_PROC        = 4,
    parameter logic [NUM_PROC-1:0] CHILD_GATE_MASK = '0,
    parameter int unsigned         DEBOUNCE        = 1,
    parameter int unsigned         STALL_W         = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_PROC-1:0] proc_idle,
    input  logic [NUM_PROC-1:0] proc_chan_block,
    input  logic [NUM_PROC-1:0] proc_axis_block,
    input  logic [NUM_PROC-1:0] child_block,
    input  logic                clear,
    output logic                block,
    output logic [NUM_PROC-1:0] block_vec,
    output logic [STALL_W-1:0]  stall_cycles
);

    localparam int unsigned         CNT_W    = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PROC-1:0]  vec_q, vec_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [NUM_PROC-1:0]  axis_eff;
    logic [NUM_PROC-1:0]  stop;
    logic                 cond;

    // A gated process's AXIS block only counts while its nested child region is itself deadlocked.
    assign axis_eff = proc_axis_block & (~CHILD_GATE_MASK | child_block);
    assign stop     = proc_idle | proc_chan_block | axis_eff;
    assign cond     = (|axis_eff) & (&stop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        stall_d = stall_q;
        if (clear) begin
            state_d = RUN;
            cnt_d   = '0;
            vec_d   = '0;
            stall_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cond) begin
                        if (DEBOUNCE == 1) begin
                            state_d = BLOCKED;
                        end else begin
                            state_d = SUSPECT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                SUSPECT: begin
                    if (!cond) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = BLOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                BLOCKED: begin
`ifdef HLS_DEADLOCK_MON_STICKY_EN
                    state_d = BLOCKED;
`else
                    if (!cond) begin
                        state_d = RUN;
                    end
`endif
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase

            // Snapshot on entry; stall count only advances while staying in BLOCKED.
            if (state_d == BLOCKED && state_q != BLOCKED) begin
                vec_d   = proc_chan_block | axis_eff;
                stall_d = STALL_W'(1);
            end else if (state_d == BLOCKED && state_q == BLOCKED) begin
                stall_d = sat_inc(stall_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            vec_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            stall_q <= stall_d;
        end
    end

    assign block        = (state_q == BLOCKED);
    assign block_vec    = vec_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Scoreboard bench: two monitor instances share random stimulus and are checked against a
// run-length reference model of the deadlock rules.
module tb_hls_deadlock_monitor_gen;

    localparam logic [3:0] MASK_A = 4'b0001;
    localparam logic [3:0] MASK_B = 4'b0110;
    localparam int         DEB_A  = 1;
    localparam int         DEB_B  = 8;
    localparam int         SMAX_A = 65535;
    localparam int         SMAX_B = 15;
`ifdef HLS_DEADLOCK_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  proc_idle = '0;
    logic [3:0]  proc_chan_block = '0;
    logic [3:0]  proc_axis_block = '0;
    logic [3:0]  child_block = '0;

    logic        block_a;
    logic [3:0]  vec_a;
    logic [15:0] st_a;
    logic        block_b;
    logic [3:0]  vec_b;
    logic [3:0]  st_b;

    always #5 clock = ~clock;

    hls_deadlock_monitor_gen #(
        .NUM_PROC(4), .CHILD_GATE_MASK(MASK_A), .DEBOUNCE(DEB_A), .STALL_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .proc_idle(proc_idle), .proc_chan_block(proc_chan_block),
        .proc_axis_block(proc_axis_block), .child_block(child_block), .clear(clear),
        .block(block_a), .block_vec(vec_a), .stall_cycles(st_a)
    );

    hls_deadlock_monitor_gen #(
        .NUM_PROC(4), .CHILD_GATE_MASK(MASK_B), .DEBOUNCE(DEB_B), .STALL_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .proc_idle(proc_idle), .proc_chan_block(proc_chan_block),
        .proc_axis_block(proc_axis_block), .child_block(child_block), .clear(clear),
        .block(block_b), .block_vec(vec_b), .stall_cycles(st_b)
    );

    typedef struct packed {
        logic        blk_a;
        logic [3:0]  vec_a;
        logic [15:0] st_a;
        logic        blk_b;
        logic [3:0]  vec_b;
        logic [3:0]  st_b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 1'b0;

    // Reference model: consecutive-cond run length per instance instead of an explicit FSM.
    bit         m_blk[2];
    int         m_run[2];
    logic [3:0] m_vec[2];
    int         m_stall[2];

    task automatic model_step(input int k);
        logic [3:0] mask;
        logic [3:0] ae;
        int         deb;
        int         smax;
        bit         c;
        bit         nb;
        mask = (k == 0) ? MASK_A : MASK_B;
        deb  = (k == 0) ? DEB_A : DEB_B;
        smax = (k == 0) ? SMAX_A : SMAX_B;
        ae   = proc_axis_block & (~mask | child_block);
        c    = (ae != 4'b0) && ((proc_idle | proc_chan_block | ae) == 4'b1111);
        if (reset || clear) begin
            m_blk[k]   = 1'b0;
            m_run[k]   = 0;
            m_vec[k]   = '0;
            m_stall[k] = 0;
        end else begin
            m_run[k] = c ? m_run[k] + 1 : 0;
            nb = (c && m_run[k] >= deb) || (STICKY && m_blk[k]);
            if (nb && !m_blk[k]) begin
                m_vec[k]   = proc_chan_block | ae;
                m_stall[k] = 1;
            end else if (nb && m_blk[k]) begin
                m_stall[k] = (m_stall[k] >= smax) ? smax : m_stall[k] + 1;
            end
            m_blk[k] = nb;
        end
    endtask

    task automatic apply(input logic [3:0] i, input logic [3:0] ch, input logic [3:0] ax,
                         input logic [3:0] cb, input logic clr, input logic rst);
        exp_t e;
        @(negedge clock);
        proc_idle       = i;
        proc_chan_block = ch;
        proc_axis_block = ax;
        child_block     = cb;
        clear           = clr;
        reset           = rst;
        model_step(0);
        model_step(1);
        e.blk_a = m_blk[0];
        e.vec_a = m_vec[0];
        e.st_a  = 16'(m_stall[0]);
        e.blk_b = m_blk[1];
        e.vec_b = m_vec[1];
        e.st_b  = 4'(m_stall[1]);
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic hold(input logic [3:0] i, input logic [3:0] ch, input logic [3:0] ax,
                        input logic [3:0] cb, input int n);
        for (int k = 0; k < n; k++) apply(i, ch, ax, cb, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        wait (started);
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty cycle=%0d actual=0 required=1", cyc);
            end else begin
                e = q.pop_front();
                check("a_block", {31'b0, block_a}, {31'b0, e.blk_a});
                check("a_block_vec", {28'b0, vec_a}, {28'b0, e.vec_a});
                check("a_stall", {16'b0, st_a}, {16'b0, e.st_a});
                check("b_block", {31'b0, block_b}, {31'b0, e.blk_b});
                check("b_block_vec", {28'b0, vec_b}, {28'b0, e.vec_b});
                check("b_stall", {28'b0, st_b}, {28'b0, e.st_b});
            end
        end
    end

    initial begin : stimulus
        logic [3:0] bi, bc, ba, bb, gi;
        int         len, kind;
        logic       clr, rst;
        for (int k = 0; k < 3; k++) apply(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        hold(4'h0, 4'h0, 4'h0, 4'h0, 6);
        // Bit 0 AXIS block, others idle: gated in A until child raises, ungated in B.
        hold(4'b1110, 4'h0, 4'b0001, 4'h0, 30);
        hold(4'b1110, 4'h0, 4'b0001, 4'b0001, 100);
        hold(4'h0, 4'h0, 4'h0, 4'h0, 3);
        // Debounce restart: 5 cycles high, one low, then held.
        hold(4'b1110, 4'b0100, 4'b0001, 4'b0001, 5);
        hold(4'b0110, 4'h0, 4'b0001, 4'b0001, 1);
        hold(4'b1110, 4'b0100, 4'b0001, 4'b0001, 12);
        apply(4'b1110, 4'b0100, 4'b0001, 4'b0001, 1'b1, 1'b0);
        hold(4'b1110, 4'b0100, 4'b0001, 4'b0001, 12);
        hold(4'h0, 4'h0, 4'h0, 4'h0, 4);
        // Reset in SUSPECT, then in BLOCKED, with cond held throughout.
        hold(4'b1010, 4'b0100, 4'b0011, 4'b0011, 4);
        apply(4'b1010, 4'b0100, 4'b0011, 4'b0011, 1'b0, 1'b1);
        hold(4'b1010, 4'b0100, 4'b0011, 4'b0011, 12);
        apply(4'b1010, 4'b0100, 4'b0011, 4'b0011, 1'b0, 1'b1);
        hold(4'b1010, 4'b0100, 4'b0011, 4'b0011, 10);
        for (int s = 0; s < 150; s++) begin
            len  = $urandom_range(1, 40);
            kind = $urandom_range(0, 2);
            ba = 4'($urandom_range(1, 15));
            bc = 4'($urandom_range(0, 15));
            bi = 4'($urandom_range(0, 15)) | ~(ba | bc);
            bb = 4'($urandom_range(0, 15));
            for (int k = 0; k < len; k++) begin
                clr = ($urandom_range(0, 99) < 2);
                rst = ($urandom_range(0, 199) < 1);
                if (kind == 0) begin
                    apply(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), clr, rst);
                end else if (kind == 2 && $urandom_range(0, 99) < 15) begin
                    gi = bi & ~(4'b0001 << $urandom_range(0, 3));
                    apply(gi, bc, ba, bb ^ 4'($urandom), clr, rst);
                end else begin
                    apply(bi, bc, ba, bb, clr, rst);
                end
            end
        end
        @(posedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_monitor_gen.md
# hls_deadlock_monitor_gen

Parametrised deadlock monitor for one dataflow region of the GenerateProof accelerator. It generalises the fixed four-process per-region monitors to NUM_PROC processes. It adds three things the fixed monitors lack: gating of each process's AXIS-block contribution by nested child monitors, a debounce threshold, and a capture of the blocked-process vector with a stall-duration counter. One instance per dataflow region. Instances nest: a child's `block` drives a parent's `child_block[i]`.

## Interface

Parameters:
- NUM_PROC, 4: number of processes in the region (1..32).
- CHILD_GATE_MASK, {NUM_PROC{1'b0}}: bit i set means process i's AXIS block counts only while `child_block[i]` is high.
- DEBOUNCE, 1: consecutive stop cycles required before `block` asserts (1..255).
- STALL_W, 16: width of `stall_cycles`.

Ports:
- clock, in, 1: sole clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- proc_idle, in, NUM_PROC: per-process idle.
- proc_chan_block, in, NUM_PROC: per-process FIFO/channel block.
- proc_axis_block, in, NUM_PROC: per-process OR of its AXIS stream block signals.
- child_block, in, NUM_PROC: `block` outputs of nested monitors; bits are ignored where the CHILD_GATE_MASK bit is 0.
- clear, in, 1: synchronous release of detection state.
- block, out, 1: deadlock detected.
- block_vec, out, NUM_PROC: processes that were channel- or AXIS-blocked on the cycle detection fired.
- stall_cycles, out, STALL_W: cycles spent in BLOCKED, saturating.

## Operation

Combinational terms:
- axis_eff[i] = proc_axis_block[i] & (~CHILD_GATE_MASK[i] | child_block[i]).
- stop[i] = proc_idle[i] | proc_chan_block[i] | axis_eff[i].
- cond = (|axis_eff) & (&stop).

State machine, states RUN, SUSPECT, BLOCKED (reset state RUN):
- RUN:
  - cond and DEBOUNCE==1 -> BLOCKED.
  - cond and DEBOUNCE>1 -> SUSPECT, with cnt=1.
- SUSPECT:
  - ~cond -> RUN, with cnt=0.
  - cond and cnt==DEBOUNCE-1 -> BLOCKED.
  - otherwise cnt++.
- BLOCKED:
  - non-sticky build: ~cond -> RUN.
  - sticky build: remain until `clear` or `reset`.
- `clear` in any state -> RUN; cnt, block_vec and stall_cycles all go to 0. `clear` has priority over cond on the same cycle.

Outputs and counters:
- `block` = (state==BLOCKED), registered.
- On entry to BLOCKED: block_vec <= proc_chan_block | axis_eff, sampled that cycle. block_vec then holds until the next entry, `clear` or `reset`.
- stall_cycles:
  - loads 1 on entry to BLOCKED;
  - increments each further BLOCKED cycle, saturating at 2^STALL_W-1;
  - holds its value after leaving BLOCKED;
  - reloads on the next entry.
- cnt width is $clog2(DEBOUNCE+1). It never wraps.

## Timing

- Reset values: block=0, block_vec=0, stall_cycles=0, state RUN.
- If cond first goes high in cycle t and stays high, `block` is high from cycle t+DEBOUNCE. With DEBOUNCE=1 this is one cycle of latency, identical to the fixed monitors.
- A single-cycle drop of cond during SUSPECT restarts the debounce count from zero.
- Non-sticky build: `block` falls one cycle after cond falls.
- A `clear` in cycle t forces block=0 in cycle t+1, even if cond is held high. Re-detection then needs a further DEBOUNCE cycles.
- `reset` mid-operation returns every output to its reset value on the next edge.
- Input path is combinational to one register stage. Inputs carry no handshake.

## Configuration

- HLS_DEADLOCK_MON_STICKY_EN defined: BLOCKED is latched. `block` stays high after cond falls, and only `clear` or `reset` release it. This mode is for post-mortem readout.
- Undefined: BLOCKED exits as soon as cond is low. `block` tracks the live condition, delayed by the debounce.

## Test plan

- NUM_PROC=4, DEBOUNCE=1; proc_axis_block=0001, proc_idle=1110 at cycle 10 -> block=1 at cycle 11, block_vec=0001, stall_cycles=1.
- CHILD_GATE_MASK=0001, child_block=0, same stimulus -> block stays 0. Raise child_block[0] at cycle 20 -> block=1 at cycle 21.
- DEBOUNCE=8; cond high cycles 10–14, low at 15, high again from 16 -> block=1 first at cycle 24.
- Non-sticky build: cond held 100 cycles then dropped -> stall_cycles=100, block falls next cycle. STALL_W=4 with cond held 40 cycles -> stall_cycles=15.
- Sticky build: cond drops after detection -> block remains 1. Assert `clear` while cond is high -> block=0 next cycle, re-asserts DEBOUNCE cycles later.
- Reset asserted while in SUSPECT and again while in BLOCKED -> all outputs 0 next cycle. No detection fires until cond has persisted DEBOUNCE cycles after reset is released.
